// File: rtl/wb_io_decoder.sv
// wb_io_decoder: Wishbone single-master to NUM_SLAVES address decoder.
// Decodes the master address against per-slave MATCH_ADDR/MATCH_MASK (lowest
// index wins), runs one access at a time through IDLE/ACCESS/RESP/DECERR,
// and reports decode, slave and timeout errors on wbm_err_o with a latched
// error address and a saturating error count.
// Optional feature: define WB_IO_DECODER_TIMEOUT_EN to enable the slave
// no-response timeout (TIMEOUT_CYCLES ACCESS cycles).
module wb_io_decoder #(
    parameter int unsigned                NUM_SLAVES     = 8,
    parameter logic [NUM_SLAVES*32-1:0]   MATCH_ADDR     = '0,
    parameter logic [NUM_SLAVES*32-1:0]   MATCH_MASK     = '0,
    parameter int unsigned                TIMEOUT_CYCLES = 255
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_i,
    input  logic [31:0]                wbm_adr_i,
    input  logic [31:0]                wbm_dat_i,
    input  logic [3:0]                 wbm_sel_i,
    input  logic                       wbm_we_i,
    input  logic                       wbm_cyc_i,
    input  logic                       wbm_stb_i,
    input  logic [2:0]                 wbm_cti_i,
    input  logic [1:0]                 wbm_bte_i,
    output logic [31:0]                wbm_dat_o,
    output logic                       wbm_ack_o,
    output logic                       wbm_err_o,
    output logic                       wbm_rty_o,
    output logic [NUM_SLAVES*32-1:0]   wbs_adr_o,
    output logic [NUM_SLAVES*32-1:0]   wbs_dat_o,
    output logic [NUM_SLAVES*4-1:0]    wbs_sel_o,
    output logic [NUM_SLAVES-1:0]      wbs_we_o,
    output logic [NUM_SLAVES-1:0]      wbs_cyc_o,
    output logic [NUM_SLAVES-1:0]      wbs_stb_o,
    output logic [NUM_SLAVES*3-1:0]    wbs_cti_o,
    output logic [NUM_SLAVES*2-1:0]    wbs_bte_o,
    input  logic [NUM_SLAVES*32-1:0]   wbs_dat_i,
    input  logic [NUM_SLAVES-1:0]      wbs_ack_i,
    input  logic [NUM_SLAVES-1:0]      wbs_err_i,
    input  logic [NUM_SLAVES-1:0]      wbs_rty_i,
    output logic [31:0]                err_adr_o,
    output logic [7:0]                 err_cnt_o
);

    localparam int unsigned IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;
    localparam logic [1:0] DECERR = 2'd3;

    if (NUM_SLAVES < 1 || NUM_SLAVES > 16 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_cfg
        $error("wb_io_decoder: NUM_SLAVES must be 1..16 and TIMEOUT_CYCLES 1..65535");
    end

    logic [1:0]       state;
    logic [IDX_W-1:0] sel_idx;
    logic [IDX_W-1:0] hit_idx;
    logic             hit;
    logic             resp_ack;
    logic             resp_err;
    logic             resp_rty;
    logic             sel_ack;
    logic             sel_err;
    logic             sel_rty;
    logic [31:0]      sel_dat;
    logic             slave_active;
    logic             timeout;
    logic             log_err;

    // Address decode: first (lowest-index) matching slave wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (!hit && ((wbm_adr_i & MATCH_MASK[i*32 +: 32]) ==
                         (MATCH_ADDR[i*32 +: 32] & MATCH_MASK[i*32 +: 32]))) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    // Pick the response lines of the slave registered for this access.
    always_comb begin
        sel_ack = 1'b0;
        sel_err = 1'b0;
        sel_rty = 1'b0;
        sel_dat = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (sel_idx == IDX_W'(i)) begin
                sel_ack = wbs_ack_i[i];
                sel_err = wbs_err_i[i];
                sel_rty = wbs_rty_i[i];
                sel_dat = wbs_dat_i[i*32 +: 32];
            end
        end
    end

    // Broadcast master request to all slaves; only the selected one sees cyc/stb.
    // Reset gates cyc/stb immediately so a slave is released in the reset cycle.
    always_comb begin
        slave_active = (state == ACCESS) && !wb_rst_i;
        wbs_adr_o    = '0;
        wbs_dat_o    = '0;
        wbs_sel_o    = '0;
        wbs_we_o     = '0;
        wbs_cti_o    = '0;
        wbs_bte_o    = '0;
        wbs_cyc_o    = '0;
        wbs_stb_o    = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            wbs_adr_o[i*32 +: 32] = wbm_adr_i;
            wbs_dat_o[i*32 +: 32] = wbm_dat_i;
            wbs_sel_o[i*4 +: 4]   = wbm_sel_i;
            wbs_we_o[i]           = wbm_we_i;
            wbs_cti_o[i*3 +: 3]   = wbm_cti_i;
            wbs_bte_o[i*2 +: 2]   = wbm_bte_i;
            wbs_cyc_o[i]          = slave_active && (sel_idx == IDX_W'(i));
            wbs_stb_o[i]          = slave_active && (sel_idx == IDX_W'(i));
        end
    end

`ifdef WB_IO_DECODER_TIMEOUT_EN
    logic [15:0] to_cnt;

    // Count ACCESS cycles; held at zero outside ACCESS so every entry starts fresh.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || state != ACCESS) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 16'd1;
        end
    end

    // Timeout fires in the TIMEOUT_CYCLES-th ACCESS cycle without a response.
    always_comb begin
        timeout = (state == ACCESS) && (to_cnt == 16'(TIMEOUT_CYCLES - 1));
    end
`else
    // No timeout: ACCESS waits for the slave indefinitely.
    always_comb begin
        timeout = 1'b0;
    end
`endif

    // Flag any access that will end in a master error (decode, slave, timeout).
    always_comb begin
        log_err = 1'b0;
        if (state == IDLE && wbm_cyc_i && wbm_stb_i && !hit) begin
            log_err = 1'b1;
        end else if (state == ACCESS && wbm_cyc_i) begin
            log_err = sel_err || (!sel_ack && !sel_rty && timeout);
        end
    end

    // Access sequencer: decode, wait for the slave, present one response cycle.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            sel_idx   <= '0;
            resp_ack  <= 1'b0;
            resp_err  <= 1'b0;
            resp_rty  <= 1'b0;
            wbm_dat_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (wbm_cyc_i && wbm_stb_i) begin
                        sel_idx <= hit_idx;
                        state   <= hit ? ACCESS : DECERR;
                    end
                end
                ACCESS: begin
                    if (!wbm_cyc_i) begin
                        state <= IDLE;
                    end else if (sel_ack || sel_err || sel_rty) begin
                        // err dominates, then ack, then rty: exactly one is reported
                        state     <= RESP;
                        wbm_dat_o <= sel_dat;
                        resp_err  <= sel_err;
                        resp_ack  <= sel_ack && !sel_err;
                        resp_rty  <= sel_rty && !sel_err && !sel_ack;
                    end else if (timeout) begin
                        state    <= RESP;
                        resp_err <= 1'b1;
                        resp_ack <= 1'b0;
                        resp_rty <= 1'b0;
                    end
                end
                RESP:    state <= IDLE;
                DECERR:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Error log: address of the latest errored access and a saturating count.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            err_adr_o <= '0;
            err_cnt_o <= '0;
        end else if (log_err) begin
            err_adr_o <= wbm_adr_i;
            if (err_cnt_o != 8'hFF) begin
                err_cnt_o <= err_cnt_o + 8'd1;
            end
        end
    end

    // Master response lines, active for the single RESP/DECERR cycle.
    always_comb begin
        wbm_ack_o = !wb_rst_i && (state == RESP) && resp_ack;
        wbm_rty_o = !wb_rst_i && (state == RESP) && resp_rty;
        wbm_err_o = !wb_rst_i && (((state == RESP) && resp_err) || (state == DECERR));
    end

endmodule

// File: tb/tb_wb_io_decoder.sv
// tb_wb_io_decoder: randomized self-checking bench for wb_io_decoder.
// Each transaction is scheduled from the decoder rules as absolute-cycle
// expectations; one negedge process compares all outputs every cycle.
module tb_wb_io_decoder;

    localparam int NS = 2;
    localparam int T  = 4;
    localparam logic [31:0] A0 = 32'h0000_0000;
    localparam logic [31:0] A1 = 32'h0000_1000;
    localparam logic [31:0] K0 = 32'hFFFF_F000;
    localparam logic [31:0] K1 = 32'hFFFF_FFC0;
`ifdef WB_IO_DECODER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] m_adr = '0, m_dat = '0;
    logic [3:0]  m_sel = '0;
    logic        m_we = 1'b0, m_cyc = 1'b0, m_stb = 1'b0;
    logic [2:0]  m_cti = '0;
    logic [1:0]  m_bte = '0;
    logic [31:0] wbm_dat_o, err_adr_o;
    logic        wbm_ack_o, wbm_err_o, wbm_rty_o;
    logic [7:0]  err_cnt_o;
    logic [63:0] wbs_adr_o, wbs_dat_o;
    logic [7:0]  wbs_sel_o;
    logic [1:0]  wbs_we_o, wbs_cyc_o, wbs_stb_o, wbs_bte_o_unused;
    logic [5:0]  wbs_cti_o;
    logic [3:0]  wbs_bte_o;
    logic [63:0] s_dat = '0;
    logic [1:0]  s_ack = '0, s_err = '0, s_rty = '0;

    wb_io_decoder #(
        .NUM_SLAVES     (NS),
        .MATCH_ADDR     ({A1, A0}),
        .MATCH_MASK     ({K1, K0}),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .wb_clk_i  (clk),       .wb_rst_i  (rst),
        .wbm_adr_i (m_adr),     .wbm_dat_i (m_dat),     .wbm_sel_i (m_sel),
        .wbm_we_i  (m_we),      .wbm_cyc_i (m_cyc),     .wbm_stb_i (m_stb),
        .wbm_cti_i (m_cti),     .wbm_bte_i (m_bte),
        .wbm_dat_o (wbm_dat_o), .wbm_ack_o (wbm_ack_o), .wbm_err_o (wbm_err_o),
        .wbm_rty_o (wbm_rty_o),
        .wbs_adr_o (wbs_adr_o), .wbs_dat_o (wbs_dat_o), .wbs_sel_o (wbs_sel_o),
        .wbs_we_o  (wbs_we_o),  .wbs_cyc_o (wbs_cyc_o), .wbs_stb_o (wbs_stb_o),
        .wbs_cti_o (wbs_cti_o), .wbs_bte_o (wbs_bte_o),
        .wbs_dat_i (s_dat),     .wbs_ack_i (s_ack),     .wbs_err_i (s_err),
        .wbs_rty_i (s_rty),
        .err_adr_o (err_adr_o), .err_cnt_o (err_cnt_o)
    );

    assign wbs_bte_o_unused = '0;

    always #5 clk = ~clk;

    int cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Expectations keyed by absolute cycle number
    logic [2:0]  exp_resp [int];
    logic [1:0]  exp_scyc [int];
    logic [31:0] upd_dat  [int];
    logic [31:0] upd_eadr [int];
    logic [7:0]  upd_ecnt [int];
    logic [31:0] cur_dat = '0, cur_eadr = '0;
    logic [7:0]  cur_ecnt = '0;
    int          err_total = 0;

    int n_cmp = 0, n_bad = 0;
    bit chk_en = 1'b0;
    int n_ack = 0, n_err = 0, n_rty = 0, last_ack_cyc = -1, last_err_cyc = -1;
    logic [1:0] scyc_seen = '0, scyc_at_err = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc_n, act, exp);
        end
    endtask

    function automatic int decode(input logic [31:0] a);
        if ((a & K0) == (A0 & K0)) return 0;
        if ((a & K1) == (A1 & K1)) return 1;
        return -1;
    endfunction

    // Per-cycle comparison against the scheduled expectations
    always @(negedge clk) begin
        logic [2:0] er;
        logic [1:0] es;
        if (chk_en) begin
            if (upd_dat.exists(cyc_n))  cur_dat  = upd_dat[cyc_n];
            if (upd_eadr.exists(cyc_n)) cur_eadr = upd_eadr[cyc_n];
            if (upd_ecnt.exists(cyc_n)) cur_ecnt = upd_ecnt[cyc_n];
            er = exp_resp.exists(cyc_n) ? exp_resp[cyc_n] : 3'b000;
            es = exp_scyc.exists(cyc_n) ? exp_scyc[cyc_n] : 2'b00;
            chk("resp_ack_err_rty", {wbm_ack_o, wbm_err_o, wbm_rty_o}, er);
            chk("slave_cyc", wbs_cyc_o, es);
            chk("slave_stb", wbs_stb_o, es);
            chk("rdata", wbm_dat_o, cur_dat);
            chk("err_adr", err_adr_o, cur_eadr);
            chk("err_cnt", err_cnt_o, cur_ecnt);
            chk("bcast_adr", wbs_adr_o, {m_adr, m_adr});
            chk("bcast_dat", wbs_dat_o, {m_dat, m_dat});
            chk("bcast_ctl", {wbs_sel_o, wbs_we_o, wbs_cti_o, wbs_bte_o},
                {m_sel, m_sel, m_we, m_we, m_cti, m_cti, m_bte, m_bte});
            if (wbm_ack_o) begin n_ack++; last_ack_cyc = cyc_n; end
            if (wbm_err_o) begin n_err++; last_err_cyc = cyc_n; scyc_at_err = wbs_cyc_o; end
            if (wbm_rty_o) n_rty++;
            scyc_seen |= wbs_cyc_o;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        s_ack = '0; s_err = '0; s_rty = '0;
    endtask

    // Random data on all slaves; random response lines on every slave but tgt
    task automatic noise(input int tgt);
        for (int i = 0; i < NS; i++) begin
            s_dat[i*32 +: 32] = $urandom;
            if (i == tgt) begin
                s_ack[i] = 1'b0; s_err[i] = 1'b0; s_rty[i] = 1'b0;
            end else begin
                s_ack[i] = ($urandom_range(0, 3) == 0);
                s_err[i] = ($urandom_range(0, 3) == 0);
                s_rty[i] = ($urandom_range(0, 3) == 0);
            end
        end
    endtask

    task automatic log_err(input int c, input logic [31:0] a);
        err_total++;
        upd_eadr[c] = a;
        upd_ecnt[c] = (err_total > 255) ? 8'd255 : 8'(err_total);
    endtask

    // One master access. lat: ACCESS cycle index in which the slave answers;
    // rt: slave {ack,err,rty}; ab: ACCESS cycle index where master drops cyc (-1 none).
    task automatic run_txn(input logic [31:0] a, input int lat, input logic [2:0] rt,
                           input int ab, input logic [31:0] sdat);
        int s, tgt, acc;
        bit slv_resp;
        logic [2:0] kind;
        s = cyc_n;
        tgt = decode(a);
        m_adr = a; m_dat = $urandom; m_sel = 4'($urandom); m_we = 1'($urandom);
        m_cti = 3'($urandom); m_bte = 2'($urandom); m_cyc = 1'b1; m_stb = 1'b1;
        noise(tgt);
        if (tgt < 0) begin
            exp_resp[s+1] = 3'b010;
            log_err(s + 1, a);
            tick(); noise(-1);
            tick(); m_cyc = 1'b0; m_stb = 1'b0; quiet();
            return;
        end
        slv_resp = 1'b0;
        kind = 3'b000;
        if (ab >= 0) begin
            acc = ab + 1;
        end else if (TO_EN && lat >= T) begin
            acc = T; kind = 3'b010;
        end else begin
            acc = lat + 1; slv_resp = 1'b1;
            kind = rt[1] ? 3'b010 : (rt[2] ? 3'b100 : 3'b001);
        end
        for (int k = 0; k < acc; k++) exp_scyc[s+1+k] = 2'b01 << tgt;
        if (kind != 3'b000) begin
            exp_resp[s+1+acc] = kind;
            if (kind == 3'b010) log_err(s + 1 + acc, a);
        end
        if (slv_resp) upd_dat[s+1+acc] = sdat;
        for (int k = 0; k < acc; k++) begin
            tick(); noise(tgt);
            if (slv_resp && k == lat) begin
                s_ack[tgt] = rt[2]; s_err[tgt] = rt[1]; s_rty[tgt] = rt[0];
                s_dat[tgt*32 +: 32] = sdat;
            end
            if (k == ab) begin m_cyc = 1'b0; m_stb = 1'b0; end
        end
        tick(); noise(tgt);
        if (ab >= 0) return;
        tick(); m_cyc = 1'b0; m_stb = 1'b0; quiet();
    endtask

    logic [2:0] rts [6] = '{3'b100, 3'b010, 3'b001, 3'b110, 3'b011, 3'b111};
    int s0, e0, a0, r0, rsel, lat, ab, lim, gap;
    logic [31:0] addr;

    initial begin
        tick(); chk_en = 1'b1;
        tick(); rst = 1'b0;

        // Decode error on unmapped 0x5000
        scyc_seen = '0; e0 = n_err;
        run_txn(32'h0000_5000, 0, 3'b000, -1, 32'h0);
        @(negedge clk);
        chk("decerr_adr", err_adr_o, 32'h0000_5000);
        chk("decerr_cnt", err_cnt_o, 8'd1);
        chk("decerr_one_cycle", n_err - e0, 1);
        chk("decerr_no_slave_cyc", scyc_seen, 2'b00);

        // Read 0x1004 hits slave1 only, ack in first ACCESS cycle
        scyc_seen = '0; s0 = cyc_n;
        run_txn(32'h0000_1004, 0, 3'b100, -1, 32'hCAFE_F00D);
        @(negedge clk);
        chk("read_data", wbm_dat_o, 32'hCAFE_F00D);
        chk("read_ack_latency", last_ack_cyc - s0, 2);
        chk("read_only_slave1", scyc_seen, 2'b10);

        // Slave ack+err together: master sees err only
        e0 = n_err; a0 = n_ack;
        run_txn(32'h0000_0040, 1, 3'b110, -1, 32'h1234_5678);
        @(negedge clk);
        chk("ackerr_err", n_err - e0, 1);
        chk("ackerr_no_ack", n_ack - a0, 0);

`ifdef WB_IO_DECODER_TIMEOUT_EN
        // Silent slave times out after 4 ACCESS cycles
        s0 = cyc_n; e0 = n_err;
        run_txn(32'h0000_0100, 100, 3'b100, -1, 32'h0);
        @(negedge clk);
        chk("timeout_err_cycle", last_err_cyc - s0, 5);
        chk("timeout_err_once", n_err - e0, 1);
        chk("timeout_cyc_dropped", scyc_at_err, 2'b00);
`else
        // Silent slave: still waiting after 20 cycles, then master abandons
        r0 = n_ack + n_err + n_rty; scyc_seen = '0;
        run_txn(32'h0000_0100, 1000, 3'b100, 19, 32'h0);
        @(negedge clk);
        chk("no_timeout_no_resp", n_ack + n_err + n_rty - r0, 0);
        chk("no_timeout_slave0", scyc_seen, 2'b01);
`endif

        // Master drops cyc in the 2nd ACCESS cycle
        r0 = n_ack + n_err + n_rty;
        run_txn(32'h0000_1008, 5, 3'b100, 1, 32'h0);
        @(negedge clk);
        chk("abort_no_resp", n_ack + n_err + n_rty - r0, 0);

        // Randomized traffic
        for (int n = 0; n < 150; n++) begin
            rsel = $urandom_range(0, 9);
            if (rsel < 2)      addr = 32'h0000_2000 | 32'($urandom);
            else if (rsel < 6) addr = {20'h0, 12'($urandom)};
            else               addr = 32'h0000_1000 | {26'h0, 6'($urandom)};
            lat = $urandom_range(0, 5);
            ab = -1;
            if ($urandom_range(0, 9) == 0) begin
                lim = lat;
                if (TO_EN && (T - 1) < lim) lim = T - 1;
                if (lim > 0) ab = $urandom_range(0, lim - 1);
            end
            run_txn(addr, lat, rts[$urandom_range(0, 5)], ab, $urandom);
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                tick(); m_cyc = 1'b0; m_stb = 1'b0; quiet();
            end
        end

        // Reset pulsed in the 2nd ACCESS cycle of an access to slave1
        s0 = cyc_n; r0 = n_ack + n_err + n_rty;
        m_adr = 32'h0000_1010; m_cyc = 1'b1; m_stb = 1'b1; quiet();
        exp_scyc[s0+1] = 2'b10;
        tick();
        tick(); rst = 1'b1; m_cyc = 1'b0; m_stb = 1'b0;
        upd_dat[s0+3] = '0; upd_eadr[s0+3] = '0; upd_ecnt[s0+3] = '0;
        err_total = 0;
        tick(); rst = 1'b0;
        @(negedge clk);
        chk("rst_no_resp", n_ack + n_err + n_rty - r0, 0);
        chk("rst_dat_zero", wbm_dat_o, 32'h0);
        chk("rst_eadr_zero", err_adr_o, 32'h0);
        chk("rst_ecnt_zero", err_cnt_o, 8'h0);
        chk("rst_scyc_zero", wbs_cyc_o, 2'b00);

        // 300 decode errors saturate the counter
        for (int n = 0; n < 300; n++) run_txn(32'h0000_5000 + 32'(n), 0, 3'b000, -1, 32'h0);
        @(negedge clk);
        chk("err_cnt_saturated", err_cnt_o, 8'd255);

        tick(); tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_io_decoder.md
WB_IO_DECODER -- requirements
Module: wb_io_decoder

Interface
REQ-001 SHALL have parameter NUM_SLAVES, default 8; number of slave ports (1..16).
REQ-002 SHALL have parameter MATCH_ADDR, default 0; NUM_SLAVES*32-bit flattened match addresses, slave i at bits [i*32 +: 32].
REQ-003 SHALL have parameter MATCH_MASK, default 0; NUM_SLAVES*32-bit flattened masks, same packing as MATCH_ADDR.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 255; slave no-response limit in cycles (1..65535).
REQ-005 wb_clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-006 wb_rst_i  input  1  reset, synchronous, active-high.
REQ-007 wbm_adr_i/wbm_dat_i  input  32 each  master address / write data.
REQ-008 wbm_sel_i  input  4; wbm_we_i, wbm_cyc_i, wbm_stb_i  input  1 each; wbm_cti_i  input  3; wbm_bte_i  input  2; master control.
REQ-009 wbm_dat_o  output  32  read data; wbm_ack_o, wbm_err_o, wbm_rty_o  output  1 each  master response.
REQ-010 wbs_adr_o, wbs_dat_o  output  NUM_SLAVES*32; wbs_sel_o  output  NUM_SLAVES*4; wbs_we_o, wbs_cyc_o, wbs_stb_o  output  NUM_SLAVES; wbs_cti_o  output  NUM_SLAVES*3; wbs_bte_o  output  NUM_SLAVES*2; slave i at slice i.
REQ-011 wbs_dat_i  input  NUM_SLAVES*32; wbs_ack_i, wbs_err_i, wbs_rty_i  input  NUM_SLAVES  slave responses.
REQ-012 err_adr_o  output  32  address of most recent errored access; err_cnt_o  output  8  saturating error count.

Function
REQ-013 Decode: slave i matches when (wbm_adr_i & MASK_i) == (ADDR_i & MASK_i); lowest matching index wins.
REQ-014 FSM states IDLE, ACCESS, RESP, DECERR.
REQ-015 IDLE: on wbm_cyc_i & wbm_stb_i, register the winning index and go to ACCESS; with no match, go to DECERR.
REQ-016 ACCESS: selected slave's cyc/stb SHALL be 1; all other slaves' cyc/stb SHALL be 0.
REQ-017 adr/dat/sel/we/cti/bte SHALL be broadcast combinationally to every slave slice.
REQ-018 ACCESS: on the selected slave's ack/err/rty, capture dat_i and the response type and go to RESP; the slave sees stb=0 in the following cycle.
REQ-019 Simultaneous slave ack and err SHALL report err only; err and rty SHALL report err only.
REQ-020 RESP: assert exactly one captured response plus captured wbm_dat_o for one cycle, then go to IDLE.
REQ-021 DECERR: assert wbm_err_o for one cycle, then go to IDLE.
REQ-022 Latency: a slave acking in its first ACCESS cycle gives master ack 2 cycles after stb sampled in IDLE; back-to-back accesses SHALL take 3 cycles each minimum.
REQ-023 wbm_cyc_i dropping in ACCESS SHALL abort: slave cyc/stb go to 0 next cycle, state goes to IDLE, no master response.
REQ-024 Any master err response (decode, slave, or timeout) SHALL latch wbm_adr_i into err_adr_o and increment err_cnt_o, saturating at 255.
REQ-025 wbm_dat_o SHALL hold its last captured value outside RESP.

Reset
REQ-026 wb_rst_i SHALL, on the next edge, force IDLE and drive all cyc/stb/ack/err/rty to 0.
REQ-027 wb_rst_i SHALL clear wbm_dat_o, err_adr_o, err_cnt_o and the timeout counter to 0.
REQ-028 Reset asserted mid-access SHALL drop the slave cyc in the same reset cycle and produce no master response.

Configuration
REQ-029 With WB_IO_DECODER_TIMEOUT_EN defined, a 16-bit counter SHALL clear on ACCESS entry and count ACCESS cycles.
REQ-030 With WB_IO_DECODER_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES with no response SHALL go to RESP with err and drop slave cyc.
REQ-031 With WB_IO_DECODER_TIMEOUT_EN undefined, the counter SHALL be absent and ACCESS SHALL wait indefinitely.

Verification
REQ-032 NUM_SLAVES=2, ADDR={0x1000,0x0000}, MASK={0xFFFFFFC0,0xFFFFF000}; read 0x1004, slave1 acks with 0xCAFEF00D -> only slave1 cyc seen, master ack 2 cycles after stb, dat=0xCAFEF00D.
REQ-033 Same configuration, read 0x5000 -> no slave cyc, wbm_err_o for 1 cycle, err_adr_o=0x5000, err_cnt_o=1.
REQ-034 Timeout macro defined, TIMEOUT_CYCLES=4, slave silent -> err exactly 4 ACCESS cycles after entry, slave cyc dropped.
REQ-035 Slave asserts ack and err together -> master sees err only, ack=0.
REQ-036 wbm_cyc_i dropped in the 2nd ACCESS cycle, then wb_rst_i pulsed mid-access -> slave cyc 0 next cycle, no response, all outputs zero after reset.
REQ-037 Force 300 decode errors -> err_cnt_o saturates at 255.
